argmax_accuracy_unit: RTL



---
 rtl/argmax_if.sv | 31 +++
 rtl/argmax_accuracy_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/argmax_if.sv
// Request/result bundle between the layer-3 output registers and the argmax/accuracy back end.
interface argmax_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned LABEL_W   = 4,
  parameter int unsigned COUNT_W   = 10
) ();

  logic                          start;
  logic [N_CLASSES*DATA_W-1:0]   outs;
  logic [LABEL_W-1:0]            label;
  logic                          clear;
  logic                          busy;
  logic                          valid;
  logic [LABEL_W-1:0]            pred;
  logic                          eql;
  logic [COUNT_W-1:0]            correct_count;
  logic [COUNT_W-1:0]            sample_count;
  logic                          finished;

  modport master (
    output start, outs, label, clear,
    input  busy, valid, pred, eql, correct_count, sample_count, finished
  );

  modport slave (
    input  start, outs, label, clear,
    output busy, valid, pred, eql, correct_count, sample_count, finished
  );

endinterface

// File: rtl/argmax_accuracy_unit.sv
// Serially scans the latched signed output vector for its maximum, reports the winning
// class and keeps saturating counts of evaluated and correctly classified samples.
module argmax_accuracy_unit #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned LABEL_W   = 4,
  parameter int unsigned COUNT_W   = 10,
  parameter int unsigned N_SAMPLES = 750
) (
  input  logic     clk,
  input  logic     rst,
  argmax_if.slave  bus
);

  localparam int unsigned         IDX_W         = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX      = IDX_W'(N_CLASSES - 1);
  localparam logic [LABEL_W-1:0]  LAST_CLASS    = LABEL_W'(N_CLASSES - 1);
  localparam logic [COUNT_W-1:0]  COUNT_MAX     = '1;
  localparam logic [COUNT_W-1:0]  SAMPLE_TARGET = COUNT_W'(N_SAMPLES);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   vec_q [N_CLASSES];
  logic [LABEL_W-1:0]         label_q;
  logic signed [DATA_W-1:0]   max_val_q, max_val_d;
  logic [LABEL_W-1:0]         max_idx_q, max_idx_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;
  logic [LABEL_W-1:0]         pred_q, pred_d;
  logic                       eql_q, eql_d;
  logic [COUNT_W-1:0]         correct_q, correct_d;
  logic [COUNT_W-1:0]         sample_q, sample_d;
  logic                       finished_q, finished_d;
  logic                       load_c;
  logic                       hit_c;
  logic signed [DATA_W-1:0]   cand_c;

  // Next-state and datapath decisions
  always_comb begin
    state_d    = state_q;
    max_val_d  = max_val_q;
    max_idx_d  = max_idx_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    pred_d     = pred_q;
    eql_d      = eql_q;
    correct_d  = correct_q;
    sample_d   = sample_q;
    finished_d = finished_q;
    load_c     = 1'b0;
    cand_c     = vec_q[idx_q];
    // An out-of-range label can never match a real class index
    hit_c      = (max_idx_q == label_q) && (label_q <= LAST_CLASS);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_c    = 1'b1;
          max_val_d = $signed(bus.outs[DATA_W-1:0]);
          max_idx_d = '0;
          idx_d     = IDX_W'(1);
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // Strict compare so ties keep the lower index
        if (cand_c > max_val_q) begin
          max_val_d = cand_c;
          max_idx_d = LABEL_W'(idx_q);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = REPORT;
      end
      REPORT: begin
        pred_d     = max_idx_q;
        eql_d      = hit_c;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        sample_d   = (sample_q != COUNT_MAX) ? sample_q + COUNT_W'(1) : sample_q;
        correct_d  = (hit_c && correct_q != COUNT_MAX) ? correct_q + COUNT_W'(1) : correct_q;
        finished_d = (sample_d == SAMPLE_TARGET);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides a coincident report update but leaves the scan alone
    if (bus.clear) begin
      correct_d  = '0;
      sample_d   = '0;
      finished_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      label_q    <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      pred_q     <= '0;
      eql_q      <= 1'b0;
      correct_q  <= '0;
      sample_q   <= '0;
      finished_q <= 1'b0;
      for (int i = 0; i < N_CLASSES; i++) vec_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      pred_q     <= pred_d;
      eql_q      <= eql_d;
      correct_q  <= correct_d;
      sample_q   <= sample_d;
      finished_q <= finished_d;
      if (load_c) begin
        label_q <= bus.label;
        for (int i = 0; i < N_CLASSES; i++) vec_q[i] <= bus.outs[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.valid         = valid_q;
  assign bus.pred          = pred_q;
  assign bus.eql           = eql_q;
  assign bus.correct_count = correct_q;
  assign bus.sample_count  = sample_q;
  assign bus.finished      = finished_q;

endmodule
